echo_delay: RTL and testbench

// - Single-tap echo/delay effect on the audio sample stream.
// - Sits between the ADC SPI front end (12-bit sample + valid) and the DAC SPI back end (12-bit data + valid).
// - Stores past samples in an on-chip circular buffer and mixes the delayed sample into the dry sample, with feedback.
// - Output is a one-cycle valid pulse, suitable as the DAC interface's valid/data input.

---
 rtl/echo_delay_if.sv | 34 +++
 rtl/echo_delay.sv | 163 ++++++++++++++++
 tb/tb_echo_delay.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/echo_delay_if.sv
// rtl/echo_delay_if.sv - sample-in / sample-out handshake bundle for echo_delay
//
// Purpose: groups the ADC-side input handshake and the DAC-side output pulse.
// Signals:
//   in_valid  master->slave  one-cycle pulse, in_data holds a new sample
//   in_data   master->slave  unsigned offset-binary sample
//   in_ready  slave->master  1 = slave can accept a sample this cycle
//   out_valid slave->master  one-cycle pulse, out_data is valid
//   out_data  slave->master  processed sample, unsigned offset-binary
interface echo_delay_if #(
    parameter int DATA_W = 12
);
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  out_valid,
        input  out_data
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output out_valid,
        output out_data
    );
endinterface

// File: rtl/echo_delay.sv
// rtl/echo_delay.sv - single-tap echo/delay with feedback over a circular sample buffer
//
// Purpose: mixes a delayed copy of the stream into the dry sample, writing the
// dry sample plus scaled feedback back into an on-chip circular buffer.
// Ports:
//   i_clk        single clock, posedge
//   i_reset      synchronous, active-high; re-clears the buffer
//   bus          echo_delay_if.slave: in_valid/in_data/in_ready, out_valid/out_data
//   i_delay_len  echo delay in samples, 0 means DEPTH
//   i_wet_shift  wet gain 2**-i_wet_shift on the delayed sample
//   i_fb_shift   feedback gain 2**-i_fb_shift on the delayed sample written back
//   i_bypass     1 = output the dry sample; buffer still gets the dry sample
//   o_overrun    sticky; a sample arrived while in_ready was low
module echo_delay #(
    parameter int DATA_W = 12,
    parameter int ADDR_W = 10
) (
    input  logic              i_clk,
    input  logic              i_reset,
    echo_delay_if.slave       bus,
    input  logic [ADDR_W-1:0] i_delay_len,
    input  logic [2:0]        i_wet_shift,
    input  logic [2:0]        i_fb_shift,
    input  logic              i_bypass,
    output logic              o_overrun
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [DATA_W-1:0] MIDSCALE = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic signed [DATA_W+1:0] SAT_MAX = {3'b000, {(DATA_W-1){1'b1}}};
    // ~x == -x-1, so this is the most negative DATA_W-bit value
    localparam logic signed [DATA_W+1:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic [2:0] {
        ST_CLEAR,
        ST_IDLE,
        ST_READ,
        ST_CALC,
        ST_WRITE
    } state_t;

    state_t                     r_state;
    state_t                     w_next;
    logic [ADDR_W-1:0]          r_wr_ptr;
    logic [ADDR_W-1:0]          r_clr_addr;
    logic [ADDR_W-1:0]          r_rd_addr;
    logic signed [DATA_W:0]     r_s;
    logic signed [DATA_W-1:0]   r_d;
    logic signed [DATA_W-1:0]   r_w;
    logic                       r_out_valid;
    logic [DATA_W-1:0]          r_out_data;
    logic                       r_overrun;
    logic signed [DATA_W-1:0]   r_mem [DEPTH];

    logic                       w_mem_we;
    logic [ADDR_W-1:0]          w_mem_addr;
    logic signed [DATA_W-1:0]   w_mem_wdata;
    logic signed [DATA_W+1:0]   w_s_ext;
    logic signed [DATA_W-1:0]   w_d_wet;
    logic signed [DATA_W-1:0]   w_d_fb;
    logic signed [DATA_W+1:0]   w_sum_wet;
    logic signed [DATA_W+1:0]   w_sum_fb;
    logic signed [DATA_W-1:0]   w_y;
    logic signed [DATA_W-1:0]   w_w;

    function automatic logic signed [DATA_W-1:0] sat(input logic signed [DATA_W+1:0] v);
        logic signed [DATA_W+1:0] c;
        if (v > SAT_MAX) begin
            c = SAT_MAX;
        end else if (v < SAT_MIN) begin
            c = SAT_MIN;
        end else begin
            c = v;
        end
        return c[DATA_W-1:0];
    endfunction

    assign bus.in_ready  = (r_state == ST_IDLE);
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign o_overrun     = r_overrun;

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_CLEAR: if (r_clr_addr == {ADDR_W{1'b1}}) w_next = ST_IDLE;
            ST_IDLE:  if (bus.in_valid) w_next = ST_READ;
            ST_READ:  w_next = ST_CALC;
            ST_CALC:  w_next = ST_WRITE;
            ST_WRITE: w_next = ST_IDLE;
            default:  w_next = ST_CLEAR;
        endcase
    end

    // Mix arithmetic: sums are two bits wider than a sample so they never wrap
    // before saturation.
    always_comb begin
        w_s_ext   = {r_s[DATA_W], r_s};
        w_d_wet   = r_d >>> i_wet_shift;
        w_d_fb    = r_d >>> i_fb_shift;
        w_sum_wet = w_s_ext + {{2{w_d_wet[DATA_W-1]}}, w_d_wet};
        w_sum_fb  = w_s_ext + {{2{w_d_fb[DATA_W-1]}}, w_d_fb};
        if (i_bypass) begin
            w_y = r_s[DATA_W-1:0];
            w_w = r_s[DATA_W-1:0];
        end else begin
            w_y = sat(w_sum_wet);
            w_w = sat(w_sum_fb);
        end
    end

    // Single write port shared by the clear sweep and the sample write-back.
    always_comb begin
        w_mem_we    = !i_reset && ((r_state == ST_CLEAR) || (r_state == ST_WRITE));
        w_mem_addr  = (r_state == ST_CLEAR) ? r_clr_addr : r_wr_ptr;
        w_mem_wdata = (r_state == ST_CLEAR) ? '0 : r_w;
    end

    // Buffer contents are not reset; the clear sweep after reset zeroes them.
    always_ff @(posedge i_clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_addr] <= w_mem_wdata;
        end
        r_d <= r_mem[r_rd_addr];
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= ST_CLEAR;
            r_wr_ptr    <= '0;
            r_clr_addr  <= '0;
            r_rd_addr   <= '0;
            r_s         <= '0;
            r_w         <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= MIDSCALE;
            r_overrun   <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_out_valid <= 1'b0;
            if (bus.in_valid && (r_state != ST_IDLE)) begin
                r_overrun <= 1'b1;
            end
            case (r_state)
                ST_CLEAR: r_clr_addr <= r_clr_addr + 1'b1;
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        r_s       <= {1'b0, bus.in_data} - {1'b0, MIDSCALE};
                        // wraps naturally, so delay 0 reads the oldest slot
                        r_rd_addr <= r_wr_ptr - i_delay_len;
                    end
                end
                ST_CALC: begin
                    r_w         <= w_w;
                    // adding midscale to a signed sample is an MSB flip
                    r_out_data  <= {~w_y[DATA_W-1], w_y[DATA_W-2:0]};
                    r_out_valid <= 1'b1;
                end
                ST_WRITE: r_wr_ptr <= r_wr_ptr + 1'b1;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_echo_delay.sv
// tb/tb_echo_delay.sv - randomized scoreboard bench for echo_delay
module tb_echo_delay;
    localparam int DEPTH = 1024;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [9:0] delay_len = '0;
    logic [2:0] wet_shift = '0;
    logic [2:0] fb_shift = '0;
    logic       bypass = 1'b0;
    logic       overrun;

    echo_delay_if #(.DATA_W(12)) bus ();

    echo_delay #(.DATA_W(12), .ADDR_W(10)) dut (
        .i_clk       (clk),
        .i_reset     (reset),
        .bus         (bus.slave),
        .i_delay_len (delay_len),
        .i_wet_shift (wet_shift),
        .i_fb_shift  (fb_shift),
        .i_bypass    (bypass),
        .o_overrun   (overrun)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int hist[$];     // every value written back since the last reset, oldest first
    int exp_q[$];    // expected out_data
    int iss_q[$];    // cycle of the in_valid that produced it

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endfunction

    function automatic int clamp(input int v);
        if (v > 2047) return 2047;
        if (v < -2048) return -2048;
        return v;
    endfunction

    // Reference: the delayed sample is the value written D samples ago, or
    // silence if fewer than D samples have been written since reset.
    function automatic void model_issue(input int data);
        int s, dl, n, d, y, w;
        s  = data - 2048;
        dl = (delay_len == 0) ? DEPTH : int'(delay_len);
        n  = hist.size();
        d  = (n - dl >= 0) ? hist[n - dl] : 0;
        if (bypass) begin
            y = s;
            w = s;
        end else begin
            y = clamp(s + (d >>> wet_shift));
            w = clamp(s + (d >>> fb_shift));
        end
        hist.push_back(w);
        exp_q.push_back(y + 2048);
        iss_q.push_back(cyc);
    endfunction

    always @(negedge clk) begin
        if (bus.out_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out_valid", 1, 0);
            end else begin
                check("out_data", int'(bus.out_data), exp_q.pop_front());
                check("latency", cyc - iss_q.pop_front(), 3);
            end
        end
    end

    task automatic send(input int data);
        int guard = 0;
        while (!bus.in_ready && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        if (!bus.in_ready) begin
            check("in_ready_timeout", 0, 1);
        end else begin
            model_issue(data);
            bus.in_valid = 1'b1;
            bus.in_data  = data[11:0];
            @(negedge clk);
            bus.in_valid = 1'b0;
            repeat (4) @(negedge clk);
        end
    endtask

    task automatic count_clear(input string name);
        int  cycles = 0;
        bit  bad = 0;
        while (!bus.in_ready && cycles < 3000) begin
            @(posedge clk);
            cycles++;
            @(negedge clk);
            if (bus.out_valid || bus.out_data != 12'd2048) bad = 1;
        end
        check(name, cycles, DEPTH);
        check({name, "_quiet_outputs"}, int'(bad), 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        hist.delete();
        check("overrun_after_reset", int'(overrun), 0);
        count_clear("clear_cycles");
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = '0;

        // T1: reset state and clear sweep length
        @(negedge clk);
        check("reset_in_ready", int'(bus.in_ready), 0);
        check("reset_out_valid", int'(bus.out_valid), 0);
        check("reset_out_data", int'(bus.out_data), 2048);
        do_reset();

        // T2: impulse echo at delay 4
        delay_len = 10'd4; wet_shift = 3'd1; fb_shift = 3'd7; bypass = 1'b0;
        send(3048);
        repeat (5) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            send(2048);
            repeat (5) @(negedge clk);
        end

        // T3: positive and negative saturation
        delay_len = 10'd1; wet_shift = 3'd0; fb_shift = 3'd0;
        send(4095);
        send(4095);
        send(0);
        send(0);

        // T4: bypass, then the bypassed sample's echo
        bypass = 1'b1; wet_shift = 3'd1;
        send(1234);
        bypass = 1'b0;
        send(2048);

        // T5: back-to-back in_valid
        check("overrun_before", int'(overrun), 0);
        @(negedge clk);
        model_issue(3000);
        bus.in_valid = 1'b1;
        bus.in_data  = 12'd3000;
        @(negedge clk);
        bus.in_data  = 12'd100;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (6) @(negedge clk);
        check("overrun_set", int'(overrun), 1);
        send(2500);
        check("overrun_sticky", int'(overrun), 1);
        check("queue_drained_t5", exp_q.size(), 0);

        // T6a: pointer wrap with delay 0
        do_reset();
        delay_len = 10'd0; wet_shift = 3'd0; fb_shift = 3'd2; bypass = 1'b0;
        send(3900);
        for (int i = 1; i < DEPTH + 1; i++) begin
            send(int'($urandom_range(0, 4095)));
        end

        // randomized configuration mix
        for (int i = 0; i < 300; i++) begin
            delay_len = 10'($urandom_range(0, DEPTH - 1));
            wet_shift = 3'($urandom_range(0, 7));
            fb_shift  = 3'($urandom_range(0, 7));
            bypass    = ($urandom_range(0, 7) == 0);
            send(int'($urandom_range(0, 4095)));
        end
        check("queue_drained_rand", exp_q.size(), 0);

        // T6b: reset while in READ drops the sample in flight
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = 12'd4000;
        @(negedge clk);
        bus.in_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        hist.delete();
        count_clear("clear_after_midop_reset");
        repeat (5) @(negedge clk);
        check("queue_drained_final", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
